// File: rtl/mem_responder.sv
// Arbitrates a command-fetch port and a data port onto one shared ROM/RAM bus.
// Fetch assembles two consecutive ROM words; data does one RAM read or write.
module mem_responder #(
  parameter int DATA_W = 14,
  parameter int ADDR_W = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_req,
  input  logic [ADDR_W-1:0]     fetch_addr,
  output logic                  fetch_ack,
  output logic [2*DATA_W-1:0]   fetch_cmd,
  input  logic                  data_req,
  input  logic                  data_we,
  input  logic [ADDR_W-1:0]     data_addr,
  input  logic [DATA_W-1:0]     data_wdata,
  output logic                  data_ack,
  output logic [DATA_W-1:0]     data_rdata,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic                  rom_rden,
  output logic                  ram_rden,
  output logic                  ram_wren,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    F0    = 3'd1,
    F1    = 3'd2,
    F2    = 3'd3,
    D_RD  = 3'd4,
    D_CAP = 3'd5,
    D_WR  = 3'd6
  } state_t;

  localparam logic PRIO_DATA  = 1'b0;
  localparam logic PRIO_FETCH = 1'b1;

  state_t              state, state_nxt;
  logic                prio;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   cmd_hi_q;
  logic                fetch_ok, data_ok;
  logic                take_fetch, take_data;

  assign busy = (state != IDLE);

  always_comb begin
    // a port whose ack is still high is finishing its handshake, not asking again
    fetch_ok   = fetch_req && !fetch_ack;
    data_ok    = data_req && !data_ack;
    take_fetch = 1'b0;
    take_data  = 1'b0;
    state_nxt  = state;
    rom_rden   = 1'b0;
    ram_rden   = 1'b0;
    ram_wren   = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state)
      IDLE: begin
        if (fetch_ok && (!data_ok || prio == PRIO_FETCH)) take_fetch = 1'b1;
        else if (data_ok)                                 take_data  = 1'b1;
        // read/write choice is carried forward by the state itself
        if (take_fetch)     state_nxt = F0;
        else if (take_data) state_nxt = data_we ? D_WR : D_RD;
      end
      F0: begin
        rom_rden  = 1'b1;
        mem_addr  = addr_q;
        state_nxt = F1;
      end
      F1: begin
        rom_rden  = 1'b1;
        mem_addr  = addr_q + ADDR_W'(1);
        state_nxt = F2;
      end
      F2:    state_nxt = IDLE;
      D_RD: begin
        ram_rden  = 1'b1;
        mem_addr  = addr_q;
        state_nxt = D_CAP;
      end
      D_CAP: state_nxt = IDLE;
      D_WR: begin
        ram_wren  = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      prio       <= PRIO_DATA;
      addr_q     <= '0;
      wdata_q    <= '0;
      cmd_hi_q   <= '0;
      fetch_cmd  <= '0;
      data_rdata <= '0;
      fetch_ack  <= 1'b0;
      data_ack   <= 1'b0;
    end else begin
      state     <= state_nxt;
      fetch_ack <= 1'b0;
      data_ack  <= 1'b0;
      if (take_fetch) addr_q <= fetch_addr;
      if (take_data) begin
        addr_q  <= data_addr;
        wdata_q <= data_wdata;
      end
      // read data returns one cycle after its grant, so capture one state late
      case (state)
        F1: cmd_hi_q <= mem_rdata;
        F2: begin
          fetch_cmd <= {cmd_hi_q, mem_rdata};
          fetch_ack <= 1'b1;
          prio      <= PRIO_DATA;
        end
        D_CAP: begin
          data_rdata <= mem_rdata;
          data_ack   <= 1'b1;
          prio       <= PRIO_FETCH;
        end
        D_WR: begin
          data_ack <= 1'b1;
          prio     <= PRIO_FETCH;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with a registered ROM/RAM model on the shared bus.
module tb_mem_responder;
  localparam int DATA_W = 14;
  localparam int ADDR_W = 12;

  logic                clk = 1'b0;
  logic                reset;
  logic                fetch_req;
  logic [ADDR_W-1:0]   fetch_addr;
  logic                fetch_ack;
  logic [2*DATA_W-1:0] fetch_cmd;
  logic                data_req, data_we;
  logic [ADDR_W-1:0]   data_addr;
  logic [DATA_W-1:0]   data_wdata;
  logic                data_ack;
  logic [DATA_W-1:0]   data_rdata;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic                rom_rden, ram_rden, ram_wren;
  logic [DATA_W-1:0]   mem_rdata = '0;
  logic                busy;

  logic [DATA_W-1:0] rom [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];

  int n_chk = 0;
  int n_err = 0;
  logic prev_fack = 1'b0;
  logic prev_dack = 1'b0;

  mem_responder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack), .fetch_cmd(fetch_cmd),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_ack(data_ack), .data_rdata(data_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .rom_rden(rom_rden), .ram_rden(ram_rden), .ram_wren(ram_wren),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rom_rden)      mem_rdata <= rom[mem_addr];
    else if (ram_rden) mem_rdata <= ram[mem_addr];
    if (ram_wren)      ram[mem_addr] <= mem_wdata;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic invariants();
    chk("grant_onehot0", 64'($onehot0({rom_rden, ram_rden, ram_wren})), 64'd1);
    chk("fetch_ack_pulse", 64'(fetch_ack && prev_fack), 64'd0);
    chk("data_ack_pulse", 64'(data_ack && prev_dack), 64'd0);
    chk("busy_vs_state", 64'(busy), 64'(dut.state != 3'd0));
    prev_fack = fetch_ack;
    prev_dack = data_ack;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    invariants();
  endtask

  initial begin
    for (int i = 0; i < (1<<ADDR_W); i++) rom[i] = '0;
    rom[12'h010] = 14'h1ABC;
    rom[12'h011] = 14'h0123;
    rom[12'h020] = 14'h1111;
    rom[12'h021] = 14'h2222;
    rom[12'hFFF] = 14'h3C5A;
    rom[12'h000] = 14'h0777;

    reset = 1'b1; fetch_req = 1'b0; fetch_addr = '0;
    data_req = 1'b0; data_we = 1'b0; data_addr = '0; data_wdata = '0;
    #2;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_grants", 64'({rom_rden, ram_rden, ram_wren}), 64'd0);
    chk("rst_acks", 64'({fetch_ack, data_ack}), 64'd0);
    chk("rst_fetch_cmd", 64'(fetch_cmd), 64'd0);
    chk("rst_data_rdata", 64'(data_rdata), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("idle_busy", 64'(busy), 64'd0);

    // fetch at 0x010
    fetch_req = 1'b1; fetch_addr = 12'h010;
    tick();
    chk("f_F0_rden", 64'(rom_rden), 64'd1);
    chk("f_F0_addr", 64'(mem_addr), 64'h010);
    chk("f_F0_ack", 64'(fetch_ack), 64'd0);
    fetch_addr = 12'hABC;
    tick();
    chk("f_F1_rden", 64'(rom_rden), 64'd1);
    chk("f_F1_addr", 64'(mem_addr), 64'h011);
    tick();
    chk("f_F2_grant", 64'({rom_rden, ram_rden, ram_wren}), 64'd0);
    chk("f_F2_ack", 64'(fetch_ack), 64'd0);
    tick();
    chk("f_ack", 64'(fetch_ack), 64'd1);
    chk("f_cmd", 64'(fetch_cmd), 64'({14'h1ABC, 14'h0123}));
    chk("f_ack_busy", 64'(busy), 64'd0);
    tick();
    chk("f_noreaccept_busy", 64'(busy), 64'd0);
    chk("f_ack_low", 64'(fetch_ack), 64'd0);
    fetch_req = 1'b0;

    // both requests together with prio=data: write first, then fetch, then queued read
    fetch_req = 1'b1; fetch_addr = 12'h020;
    data_req = 1'b1; data_we = 1'b1; data_addr = 12'h007; data_wdata = 14'h1234;
    tick();
    chk("arb_wr_wren", 64'(ram_wren), 64'd1);
    chk("arb_wr_rom", 64'(rom_rden), 64'd0);
    chk("arb_wr_addr", 64'(mem_addr), 64'h007);
    chk("arb_wr_wdata", 64'(mem_wdata), 64'h1234);
    data_wdata = 14'h0000;
    tick();
    chk("arb_wr_ack", 64'(data_ack), 64'd1);
    chk("arb_wr_fack", 64'(fetch_ack), 64'd0);
    tick();
    chk("arb_f_F0", 64'(rom_rden), 64'd1);
    chk("arb_f_addr", 64'(mem_addr), 64'h020);
    data_we = 1'b0;
    tick();
    chk("arb_f_F1_noram", 64'(ram_rden), 64'd0);
    chk("arb_f_F1_addr", 64'(mem_addr), 64'h021);
    tick();
    tick();
    chk("arb_f_ack", 64'(fetch_ack), 64'd1);
    chk("arb_f_cmd", 64'(fetch_cmd), 64'({14'h1111, 14'h2222}));
    fetch_req = 1'b0;
    tick();
    chk("arb_rd_rden", 64'(ram_rden), 64'd1);
    chk("arb_rd_addr", 64'(mem_addr), 64'h007);
    tick();
    chk("arb_rd_cap_grant", 64'({rom_rden, ram_rden, ram_wren}), 64'd0);
    tick();
    chk("arb_rd_ack", 64'(data_ack), 64'd1);
    chk("arb_rd_data", 64'(data_rdata), 64'h1234);
    chk("arb_fcmd_hold", 64'(fetch_cmd), 64'({14'h1111, 14'h2222}));
    data_req = 1'b0;
    tick();

    // write 0x2AAA to 0x005 then read it back
    data_req = 1'b1; data_we = 1'b1; data_addr = 12'h005; data_wdata = 14'h2AAA;
    tick();
    chk("wr_wren", 64'(ram_wren), 64'd1);
    chk("wr_wdata", 64'(mem_wdata), 64'h2AAA);
    chk("wr_ack_early", 64'(data_ack), 64'd0);
    tick();
    chk("wr_ack", 64'(data_ack), 64'd1);
    chk("wr_wren_off", 64'(ram_wren), 64'd0);
    data_req = 1'b0;
    tick();
    data_req = 1'b1; data_we = 1'b0; data_addr = 12'h005;
    tick();
    chk("rd_rden", 64'(ram_rden), 64'd1);
    chk("rd_addr", 64'(mem_addr), 64'h005);
    data_addr = 12'h3FF;
    tick();
    chk("rd_ack_early", 64'(data_ack), 64'd0);
    tick();
    chk("rd_ack", 64'(data_ack), 64'd1);
    chk("rd_data", 64'(data_rdata), 64'h2AAA);
    data_req = 1'b0;
    tick();
    chk("rd_data_hold", 64'(data_rdata), 64'h2AAA);

    // fetch wrapping past the top address
    fetch_req = 1'b1; fetch_addr = 12'hFFF;
    tick();
    chk("wrap_F0_addr", 64'(mem_addr), 64'hFFF);
    tick();
    chk("wrap_F1_addr", 64'(mem_addr), 64'h000);
    chk("wrap_F1_rden", 64'(rom_rden), 64'd1);
    tick();
    tick();
    chk("wrap_ack", 64'(fetch_ack), 64'd1);
    chk("wrap_cmd", 64'(fetch_cmd), 64'({14'h3C5A, 14'h0777}));
    fetch_req = 1'b0;
    tick();

    // reset during F1 aborts; held request is served again afterwards
    fetch_req = 1'b1; fetch_addr = 12'h010;
    tick();
    tick();
    chk("abort_in_F1", 64'(rom_rden), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_grants", 64'({rom_rden, ram_rden, ram_wren}), 64'd0);
    chk("abort_mem_addr", 64'(mem_addr), 64'd0);
    chk("abort_fetch_cmd", 64'(fetch_cmd), 64'd0);
    chk("abort_data_rdata", 64'(data_rdata), 64'd0);
    tick();
    chk("abort_no_ack", 64'(fetch_ack), 64'd0);
    reset = 1'b0;
    tick();
    chk("refetch_F0", 64'(rom_rden), 64'd1);
    chk("refetch_F0_addr", 64'(mem_addr), 64'h010);
    tick();
    chk("refetch_F1_addr", 64'(mem_addr), 64'h011);
    tick();
    chk("refetch_F2_ack", 64'(fetch_ack), 64'd0);
    tick();
    chk("refetch_ack", 64'(fetch_ack), 64'd1);
    chk("refetch_cmd", 64'(fetch_cmd), 64'({14'h1ABC, 14'h0123}));
    fetch_req = 1'b0;
    tick();
    chk("end_idle", 64'(busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The module SHALL have these parameters, one per line (name, default, meaning):
- DATA_W, 14, memory word width.
- ADDR_W, 12, memory address width.

REQ-002 The module SHALL have these ports, one per line (name, direction, width, meaning). Clock and reset: one clock; reset is asynchronous and active-high.
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- fetch_req  in  1  command-fetch request; held high until fetch_ack.
- fetch_addr  in  ADDR_W  ROM address of the first command word.
- fetch_ack  out  1  one-cycle pulse; fetch_cmd is valid in the same cycle.
- fetch_cmd  out  2*DATA_W  assembled command: {word@addr, word@addr+1}.
- data_req  in  1  data request; held high until data_ack.
- data_we  in  1  1 = RAM write, 0 = RAM read.
- data_addr  in  ADDR_W  RAM address.
- data_wdata  in  DATA_W  RAM write data.
- data_ack  out  1  one-cycle pulse; completes a data transaction.
- data_rdata  out  DATA_W  RAM read result; valid when data_ack=1 on a read.
- mem_addr  out  ADDR_W  shared ROM/RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- rom_rden  out  1  ROM read grant.
- ram_rden  out  1  RAM read grant.
- ram_wren  out  1  RAM write grant.
- mem_rdata  in  DATA_W  shared read bus; valid one cycle after rden.
- busy  out  1  high whenever state != IDLE.

Function
REQ-003 The FSM SHALL have these states: IDLE, F0, F1, F2, D_RD, D_CAP, D_WR.
REQ-004 In IDLE, a port SHALL NOT be accepted while its own ack is high.
REQ-005 In IDLE, with a single eligible request, that port SHALL be accepted.
REQ-006 In IDLE, with both requests eligible, the port named by the round-robin bit prio SHALL be accepted.
REQ-007 On acceptance, the FSM SHALL latch addr, we and wdata of the accepted port.
- Next state is F0 for a fetch, D_WR for a write, D_RD for a read.
REQ-008 After a fetch completes, prio SHALL become data; after a data transaction completes, prio SHALL become fetch.
REQ-009 F0 SHALL drive rom_rden=1, mem_addr=latched addr, then go to F1.
REQ-010 F1 SHALL drive rom_rden=1, mem_addr=latched addr+1, register mem_rdata as the upper word, then go to F2.
- The addr+1 increment is modulo 2^ADDR_W: address all-ones wraps to 0.
REQ-011 F2 SHALL drive no grant.
- At the F2 exit edge: register mem_rdata as the lower word, set fetch_ack=1 for one cycle, go to IDLE.
REQ-012 D_RD SHALL drive ram_rden=1, mem_addr=latched addr, then go to D_CAP.
- At the D_CAP exit edge: register mem_rdata into data_rdata, set data_ack=1 for one cycle, go to IDLE.
REQ-013 D_WR SHALL drive ram_wren=1, mem_addr=latched addr, mem_wdata=latched wdata for exactly one cycle.
- At its exit edge: set data_ack=1 for one cycle, go to IDLE.
REQ-014 Latency, counted from the edge that samples the request in IDLE to ack high:
- fetch: 3 cycles.
- read: 2 cycles.
- write: 1 cycle.
REQ-015 Grants SHALL be decoded from state only. At most one of rom_rden, ram_rden, ram_wren SHALL be high in any cycle, and all SHALL be 0 in IDLE, F2 and D_CAP.
REQ-016 Request inputs SHALL be ignored outside IDLE. Changes to addr/data inputs after acceptance SHALL NOT affect the transaction.
REQ-017 fetch_cmd and data_rdata SHALL hold their last value until overwritten by the next completion of their own port.

Reset
REQ-018 While reset is high, the block SHALL asynchronously force:
- state=IDLE, prio=data.
- fetch_ack, data_ack, all grants, busy = 0.
- fetch_cmd, data_rdata, mem_addr, mem_wdata = 0.
REQ-019 Reset asserted mid-transaction SHALL abort it with no ack. A request still high after reset release SHALL be re-served from scratch.

Verification
REQ-020 ROM[0x010]=0x1ABC, ROM[0x011]=0x0123; fetch_req, addr 0x010 -> F0/F1 issue rom_rden at 0x010 then 0x011; fetch_ack 3 cycles later with fetch_cmd=0x1ABC_0123 (concatenated).
REQ-021 Write 0x2AAA to RAM 0x005, then read 0x005 -> ram_wren for one cycle with data_ack at +1; read data_ack at +2 with data_rdata=0x2AAA.
REQ-022 fetch_req and data_req rise in the same cycle, both held -> data served first, fetch next; a re-asserted data_req while a fetch is pending is served only after the fetch.
REQ-023 Fetch at addr 0xFFF -> second rom_rden at mem_addr 0x000; fetch_cmd={ROM[0xFFF],ROM[0x000]}.
REQ-024 Reset pulsed during F1 -> all outputs 0 immediately, no fetch_ack; after release, with fetch_req still high, a full 3-cycle fetch completes correctly.
REQ-025 Every test: a checker asserts grant mutual exclusion, one-cycle ack pulses, and busy == (state != IDLE).
